// File: rtl/dm_pkg.sv
`default_nettype none
// dm_pkg -- shared state encoding, widths and access-legality check for data_mem_responder.
// Revision 1.0
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int DM_DATA_W = 32;
  localparam int DM_ADDR_W = 32;

  // An access is illegal if it is not word aligned or its word index falls past the array.
  function automatic logic dm_is_err(input logic [DM_ADDR_W-1:0] addr,
                                     input logic [DM_ADDR_W-1:0] depth);
    logic [DM_ADDR_W-1:0] word;
    word = {2'b00, addr[DM_ADDR_W-1:2]};
    return (addr[1:0] != 2'b00) || (word >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_storage.sv
`default_nettype none
// dm_storage -- word array with one synchronous write port, one combinational read port, clear on reset.
// Revision 1.0
module dm_storage
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [DM_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [DM_DATA_W-1:0] rdata
);

  logic [DM_DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// data_mem_responder -- valid/ready data-memory slave inserting WAIT_CYCLES wait states per access.
// Revision 1.0
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [DM_ADDR_W-1:0] req_addr,
  input  logic [DM_DATA_W-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DM_DATA_W-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [DM_ADDR_W-1:0] DEPTH_VEC = DM_ADDR_W'(DEPTH_WORDS);

  dm_state_e            state;
  logic [3:0]           cnt;
  logic                 lat_write;
  logic [DM_ADDR_W-1:0] lat_addr;
  logic [DM_DATA_W-1:0] lat_wdata;

  logic                 accept;
  logic                 access;
  logic                 acc_write;
  logic [DM_ADDR_W-1:0] acc_addr;
  logic [DM_DATA_W-1:0] acc_wdata;
  logic                 acc_err;
  logic [IDX_W-1:0]     acc_idx;
  logic                 store_en;
  logic [DM_DATA_W-1:0] rd_word;
  logic [DM_DATA_W-1:0] rdata_next;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // With no wait states the access happens on the acceptance edge, so use the live request.
  assign access = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));

  assign acc_write = (state == IDLE) ? req_write : lat_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  assign acc_err    = dm_is_err(acc_addr, DEPTH_VEC);
  assign acc_idx    = acc_addr[IDX_W+1:2];
  assign store_en   = access && acc_write && !acc_err;
  assign rdata_next = (acc_write || acc_err) ? '0 : rd_word;

  dm_storage #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_storage (
    .clk  (clk),
    .rst  (rst),
    .we   (store_en),
    .waddr(acc_idx),
    .wdata(acc_wdata),
    .raddr(acc_idx),
    .rdata(rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_next;
              resp_err   <= acc_err;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_next;
            resp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// tb_data_mem_responder -- scoreboard bench for data_mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
// Revision 1.0
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   acc_cnt  = 0;
  int   lat_of[2] = '{3, 1};

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req_valid[0] && req_ready[0]) acc_cnt <= acc_cnt + 1;
  end

  // One full transaction on instance d; called and returning just after a falling edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int stall, input string tag);
    exp_t e;
    int   edges;
    bit   ok;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    resp_ready[d] = (stall == 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      $display("FAIL %s accept: req_ready stayed 0, required 1", tag);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1 req_valid[d] = 1'b0;
    edges = 1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (req_ready[d] !== 1'b0)
          $display("FAIL %s ready_drop: req_ready=%b required 0", tag, req_ready[d]);
        else pass_cnt++;
      end
      if (resp_valid[d]) begin ok = 1; break; end
      @(posedge clk);
      edges++;
    end
    if (!ok) begin
      total++;
      $display("FAIL %s timeout: resp_valid stayed 0, required 1", tag);
      void'(sb.pop_front());
      return;
    end
    total++;
    if (edges !== lat_of[d])
      $display("FAIL %s latency: %0d edges, required %0d", tag, edges, lat_of[d]);
    else pass_cnt++;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({resp_valid[d], req_ready[d], resp_rdata[d]} !== {1'b1, 1'b0, exp_rdata})
        $display("FAIL %s stall%0d: valid/ready/rdata=%b/%b/%h required 1/0/%h",
                 tag, s, resp_valid[d], req_ready[d], resp_rdata[d], exp_rdata);
      else pass_cnt++;
    end
    resp_ready[d] = 1'b1;
    e = sb.pop_front();
    total++;
    if ({resp_rdata[d], resp_err[d]} !== {e.rdata, e.err})
      $display("FAIL %s data: rdata=%h err=%b required rdata=%h err=%b",
               tag, resp_rdata[d], resp_err[d], e.rdata, e.err);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid[d], req_ready[d]} !== 2'b01)
      $display("FAIL %s idle: valid/ready=%b/%b required 0/1", tag, resp_valid[d], req_ready[d]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]} !== {1'b1, 1'b0, 32'h0, 1'b0})
        $display("FAIL reset%0d: ready/valid/rdata/err=%b/%b/%h/%b required 1/0/0/0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      else pass_cnt++;
      rst[d] = 1'b0;
    end
  endtask

  task automatic test_defaults();
    xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, "store10");
    xfer(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "load10");
  endtask

  task automatic test_errors();
    xfer(0, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 0, "misaligned");
    xfer(0, 1'b1, 32'h400, 32'hCAFE_F00D, 32'h0, 1'b1, 0, "out_of_range");
    xfer(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, "word0_unchanged");
    xfer(0, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0, 0, "last_word_legal");
  endtask

  task automatic test_backpressure();
    xfer(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, "backpressure");
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h1234_5678;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[0]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      $display("FAIL midwait accept: req_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]} !== {1'b1, 1'b0, 32'h0, 1'b0})
      $display("FAIL midwait_reset: ready/valid/rdata/err=%b/%b/%h/%b required 1/0/0/0",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
    else pass_cnt++;
    rst[0] = 1'b0;
    xfer(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0, "dropped_store");
    xfer(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, "mem_cleared");
  endtask

  task automatic test_wait0();
    xfer(1, 1'b1, 32'h3FC, 32'hA5A5_5A5C, 32'h0, 1'b0, 0, "w0_store");
    xfer(1, 1'b0, 32'h3FC, 32'h0, 32'hA5A5_5A5C, 1'b0, 0, "w0_load");
    xfer(1, 1'b1, 32'h402, 32'h1, 32'h0, 1'b1, 0, "w0_err");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    exp_t e;
    int   acc0;
    bit   ok;
    bit   ready_bad;
    for (int k = 0; k < 4; k++) vals[k] = 32'h1111_0000 + 32'(k * 32'h0101);
    acc0 = acc_cnt;
    ready_bad = 0;
    resp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[0] = 32'h0; req_wdata[0] = vals[0];
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (req_ready[0]) begin ok = 1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        total++;
        $display("FAIL b2b accept%0d: req_ready stayed 0, required 1", k);
        break;
      end
      @(posedge clk);
      e.rdata = 32'h0;
      e.err   = 1'b0;
      sb.push_back(e);
      #1;
      if (k < 3) begin
        req_addr[0]  = 32'((k + 1) * 4);
        req_wdata[0] = vals[k+1];
      end else begin
        req_valid[0] = 1'b0;
      end
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req_ready[0]) ready_bad = 1;
        if (resp_valid[0]) begin ok = 1; break; end
      end
      e = sb.pop_front();
      total++;
      if (!ok || {resp_rdata[0], resp_err[0]} !== {e.rdata, e.err})
        $display("FAIL b2b resp%0d: valid=%b rdata=%h err=%b required 1/%h/%b",
                 k, resp_valid[0], resp_rdata[0], resp_err[0], e.rdata, e.err);
      else pass_cnt++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (acc_cnt - acc0 !== 4)
      $display("FAIL b2b accepts: %0d acceptances, required 4", acc_cnt - acc0);
    else pass_cnt++;
    total++;
    if (ready_bad !== 1'b0)
      $display("FAIL b2b ready_low: req_ready seen 1 during WAIT/RESP, required 0");
    else pass_cnt++;
    for (int k = 0; k < 4; k++)
      xfer(0, 1'b0, 32'(k * 4), 32'h0, vals[k], 1'b0, 0, "b2b_readback");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_defaults();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_wait0();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
